// File: rtl/llki_key_sender.sv
// LLKI discrete key-load initiator: streams buffered 64-bit key words to a core, or requests a clear.
// Define LLKI_KEY_SENDER_TIMEOUT_EN to abort any core-side wait after TIMEOUT_CYCLES cycles.
module llki_key_sender #(
  parameter int MAX_KEY_WORDS  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               buf_wr_en,
  input  logic [$clog2(MAX_KEY_WORDS)-1:0]   buf_wr_addr,
  input  logic [63:0]                        buf_wr_data,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic                               cmd_op,
  input  logic [$clog2(MAX_KEY_WORDS+1)-1:0] cmd_num_words,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic [1:0]                         resp_status,
  output logic                               busy,
  output logic [63:0]                        llkid_key_data,
  output logic                               llkid_key_valid,
  input  logic                               llkid_key_ready,
  input  logic                               llkid_key_complete,
  output logic                               llkid_clear_key,
  input  logic                               llkid_clear_key_ack
);
  localparam int AW = $clog2(MAX_KEY_WORDS);
  localparam int CW = $clog2(MAX_KEY_WORDS + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SEND  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CLEAR = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam logic [1:0] RS_OK       = 2'b00;
  localparam logic [1:0] RS_TIMEOUT  = 2'b01;
  localparam logic [1:0] RS_BAD_LEN  = 2'b10;
  localparam logic [1:0] RS_PROTOCOL = 2'b11;

  logic [63:0]   key_mem [MAX_KEY_WORDS];

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] num_q, num_d;
  logic [63:0]   key_data_q, key_data_d;
  logic          key_valid_q, key_valid_d;
  logic          clear_q, clear_d;
  logic          resp_valid_q, resp_valid_d;
  logic [1:0]    resp_status_q, resp_status_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          word_xfer;
  logic          last_word;
  logic          tmo_hit;

  assign busy            = (state_q != ST_IDLE);
  assign cmd_ready       = cmd_ready_q;
  assign resp_valid      = resp_valid_q;
  assign resp_status     = resp_status_q;
  assign llkid_key_data  = key_data_q;
  assign llkid_key_valid = key_valid_q;
  assign llkid_clear_key = clear_q;
  assign last_word       = (CW'(idx_q) == num_q - CW'(1));

  // Writes are locked out while busy so the key in flight cannot change underneath the transfer.
  always_ff @(posedge clk) begin
    if (buf_wr_en && !busy) begin
      key_mem[buf_wr_addr] <= buf_wr_data;
    end
  end

`ifdef LLKI_KEY_SENDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Counts cycles spent waiting on the core; any state change or word transfer restarts it.
  always_comb begin
    tmo_d = '0;
    if ((state_d == state_q) && !word_xfer &&
        (state_q == ST_SEND || state_q == ST_WAIT || state_q == ST_CLEAR)) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`else
  // Timeouts disabled: waits are unbounded and the parameter only keeps the interface uniform.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    num_d         = num_q;
    key_data_d    = key_data_q;
    key_valid_d   = key_valid_q;
    clear_d       = clear_q;
    resp_valid_d  = resp_valid_q;
    resp_status_d = resp_status_q;
    word_xfer     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_op) begin
            clear_d = 1'b1;
            state_d = ST_CLEAR;
          end else if (cmd_num_words == '0 || cmd_num_words > CW'(MAX_KEY_WORDS)) begin
            resp_valid_d  = 1'b1;
            resp_status_d = RS_BAD_LEN;
            state_d       = ST_RESP;
          end else begin
            num_d       = cmd_num_words;
            idx_d       = {AW{1'b0}};
            key_data_d  = key_mem[{AW{1'b0}}];
            key_valid_d = 1'b1;
            state_d     = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        // A completion before the last word means the core and initiator disagree on key length.
        if (llkid_key_complete) begin
          key_valid_d   = 1'b0;
          resp_valid_d  = 1'b1;
          resp_status_d = RS_PROTOCOL;
          state_d       = ST_RESP;
        end else if (llkid_key_ready) begin
          word_xfer = 1'b1;
          if (last_word) begin
            key_valid_d = 1'b0;
            state_d     = ST_WAIT;
          end else begin
            idx_d      = idx_q + AW'(1);
            key_data_d = key_mem[idx_d];
          end
        end else if (tmo_hit) begin
          key_valid_d   = 1'b0;
          resp_valid_d  = 1'b1;
          resp_status_d = RS_TIMEOUT;
          state_d       = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (llkid_key_complete) begin
          resp_valid_d  = 1'b1;
          resp_status_d = RS_OK;
          state_d       = ST_RESP;
        end else if (tmo_hit) begin
          resp_valid_d  = 1'b1;
          resp_status_d = RS_TIMEOUT;
          state_d       = ST_RESP;
        end
      end
      ST_CLEAR: begin
        if (llkid_clear_key_ack || tmo_hit) begin
          clear_d       = 1'b0;
          resp_valid_d  = 1'b1;
          resp_status_d = llkid_clear_key_ack ? RS_OK : RS_TIMEOUT;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        key_valid_d  = 1'b0;
        clear_d      = 1'b0;
        resp_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      num_q         <= '0;
      key_data_q    <= '0;
      key_valid_q   <= 1'b0;
      clear_q       <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= RS_OK;
      cmd_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      num_q         <= num_d;
      key_data_q    <= key_data_d;
      key_valid_q   <= key_valid_d;
      clear_q       <= clear_d;
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

endmodule

// File: tb/tb_llki_key_sender.sv
// Scoreboard bench for llki_key_sender: a buffer model predicts words/status, a negedge monitor checks.
// The timeout scenario runs only when LLKI_KEY_SENDER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_llki_key_sender;
  localparam int MAXW = 8;
  localparam int TMO  = 16;
  localparam logic [1:0] S_OK = 2'b00, S_TMO = 2'b01, S_BAD = 2'b10, S_PROT = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        buf_wr_en = 1'b0;
  logic [2:0]  buf_wr_addr = '0;
  logic [63:0] buf_wr_data = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [3:0]  cmd_num_words = '0;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_status;
  logic        busy;
  logic [63:0] llkid_key_data;
  logic        llkid_key_valid;
  logic        llkid_key_ready = 1'b0;
  logic        llkid_key_complete = 1'b0;
  logic        llkid_clear_key;
  logic        llkid_clear_key_ack = 1'b0;

  llki_key_sender #(.MAX_KEY_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_num_words(cmd_num_words),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status), .busy(busy),
    .llkid_key_data(llkid_key_data), .llkid_key_valid(llkid_key_valid),
    .llkid_key_ready(llkid_key_ready), .llkid_key_complete(llkid_key_complete),
    .llkid_clear_key(llkid_clear_key), .llkid_clear_key_ack(llkid_clear_key_ack)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [63:0] model_buf [MAXW];
  logic [63:0] exp_words [$];
  logic [1:0]  exp_status [$];
  int          exp_clr [$];
  bit          resp_rand_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    cmp_cnt++;
    err_cnt++;
    $display("FAIL %s: got no event within bound required event", name);
  endtask

  // Response consumer: always ready by default, randomly back-pressuring when enabled.
  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      resp_ready = resp_rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: everything that happens at the next rising edge is visible at the falling edge.
  logic        hold_v = 1'b0, rhold_v = 1'b0;
  logic [63:0] hold_d;
  logic [1:0]  rhold_s;
  int          clr_run = 0;
  always @(negedge clk) begin
    if (!rst) begin
      hold_v = 1'b0; rhold_v = 1'b0; clr_run = 0;
    end else begin
      if (llkid_key_valid) begin
        if (hold_v) check("data_stable", llkid_key_data, hold_d);
        if (llkid_key_ready) begin
          if (exp_words.size() == 0) begin
            cmp_cnt++; err_cnt++;
            $display("FAIL unexpected_word: got %0h required no transfer", llkid_key_data);
          end else check("word", llkid_key_data, exp_words.pop_front());
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1; hold_d = llkid_key_data;
        end
      end else hold_v = 1'b0;

      if (resp_valid) begin
        if (rhold_v) check("status_stable", 64'(resp_status), 64'(rhold_s));
        if (resp_ready) begin
          if (exp_status.size() == 0) begin
            cmp_cnt++; err_cnt++;
            $display("FAIL unexpected_resp: got %0d required no response", resp_status);
          end else check("resp_status", 64'(resp_status), 64'(exp_status.pop_front()));
          rhold_v = 1'b0;
        end else begin
          rhold_v = 1'b1; rhold_s = resp_status;
        end
      end else rhold_v = 1'b0;

      if (llkid_clear_key) clr_run++;
      else if (clr_run > 0) begin
        if (exp_clr.size() == 0) begin
          cmp_cnt++; err_cnt++;
          $display("FAIL unexpected_clear: got %0d cycles required none", clr_run);
        end else check("clear_len", 64'(clr_run), 64'(exp_clr.pop_front()));
        clr_run = 0;
      end
    end
  end

  task automatic write_buf(input int a, input logic [63:0] d, input bit track);
    @(posedge clk); #1;
    buf_wr_en = 1'b1; buf_wr_addr = 3'(a); buf_wr_data = d;
    @(posedge clk); #1;
    buf_wr_en = 1'b0;
    if (track) model_buf[a] = d;
  endtask

  // Returns 1ns after the accepting edge.
  task automatic send_cmd(input bit op, input int n);
    int i;
    for (i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (cmd_ready) break;
    end
    if (i == 100) fail_bound("cmd_ready_wait");
    cmd_valid = 1'b1; cmd_op = op; cmd_num_words = 4'(n);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (cmd_ready) break;
    end
    if (i == 200) fail_bound("return_to_idle");
  endtask

  // mode: 0 ready tied high, 1 toggling, 2 random. prot_after > 0 raises complete after that many words.
  task automatic do_load(input int n, input int mode, input int prot_after);
    int cnt, cyc, goal;
    bit xfer;
    if (n == 0 || n > MAXW) begin
      exp_status.push_back(S_BAD);
      send_cmd(1'b0, n);
      check("badlen_next_cycle", 64'(resp_valid), 64'd1);
      check("badlen_no_valid", 64'(llkid_key_valid), 64'd0);
    end else begin
      goal = (prot_after > 0) ? prot_after : n;
      for (int w = 0; w < goal; w++) exp_words.push_back(model_buf[w]);
      exp_status.push_back((prot_after > 0) ? S_PROT : S_OK);
      send_cmd(1'b0, n);
      check("load_valid_next_cycle", 64'(llkid_key_valid), 64'd1);
      cnt = 0; cyc = 0;
      while (cnt < goal && cyc < 500) begin
        llkid_key_ready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
        @(negedge clk);
        xfer = llkid_key_valid && llkid_key_ready;
        @(posedge clk); #1;
        cyc++;
        if (xfer) cnt++;
      end
      if (cyc >= 500) fail_bound("load_transfers");
      llkid_key_ready = 1'b0;
      if (prot_after > 0) begin
        llkid_key_complete = 1'b1;
      end else begin
        check("valid_low_after_last", 64'(llkid_key_valid), 64'd0);
        if (mode == 0) check("back_to_back_cycles", 64'(cyc), 64'(n));
        repeat (2) @(posedge clk);
        #1 llkid_key_complete = 1'b1;
      end
    end
    wait_idle();
    llkid_key_complete = 1'b0;
  endtask

  // d == 0: ack already high when the clear starts (one-cycle pulse expected).
  task automatic do_clear(input int d);
    exp_clr.push_back((d == 0) ? 1 : d);
    exp_status.push_back(S_OK);
    if (d == 0) llkid_clear_key_ack = 1'b1;
    send_cmd(1'b1, 0);
    check("clear_next_cycle", 64'(llkid_clear_key), 64'd1);
    if (d > 0) begin
      repeat (d - 1) @(posedge clk);
      #1 llkid_clear_key_ack = 1'b1;
    end
    wait_idle();
    llkid_clear_key_ack = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b0;
    #3;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_status", 64'(resp_status), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_key_data", llkid_key_data, 64'd0);
    check("rst_key_valid", 64'(llkid_key_valid), 64'd0);
    check("rst_clear_key", 64'(llkid_clear_key), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("cmd_ready_in_reset", 64'(cmd_ready), 64'd0);
    rst = 1'b1;
    #1 check("cmd_ready_before_edge", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    check("cmd_ready_after_release", 64'(cmd_ready), 64'd1);

    for (int a = 0; a < MAXW; a++) write_buf(a, {8{8'(8'h11 * (a + 1))}}, 1'b1);

    do_load(4, 0, 0);
    do_load(4, 1, 0);
    do_load(0, 0, 0);
    do_load(MAXW + 1, 0, 0);
    do_clear(5);
    do_clear(0);
    do_load(3, 0, 1);

    // Reset mid-SEND with a locked-out buffer write to the next word.
    for (int w = 0; w < 3; w++) exp_words.push_back(model_buf[w]);
    exp_status.push_back(S_OK);
    send_cmd(1'b0, 3);
    write_buf(1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    llkid_key_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 llkid_key_ready = 1'b0;
    check("word2_presented", llkid_key_data, model_buf[2]);
    #2 rst = 1'b0;
    #1;
    check("midrst_key_valid", 64'(llkid_key_valid), 64'd0);
    check("midrst_key_data", llkid_key_data, 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    exp_words.delete();
    exp_status.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("cmd_ready_after_midrst", 64'(cmd_ready), 64'd1);
    do_load(2, 0, 0);

    resp_rand_en = 1'b1;
    for (int it = 0; it < 30; it++) begin
      int nw, n, kind;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++)
        write_buf($urandom_range(0, MAXW - 1), {$urandom, $urandom}, 1'b1);
      kind = $urandom_range(0, 3);
      if (kind <= 1) do_load($urandom_range(0, MAXW + 1), $urandom_range(0, 2), 0);
      else if (kind == 2) begin
        n = $urandom_range(2, MAXW);
        do_load(n, $urandom_range(0, 2), $urandom_range(1, n - 1));
      end else do_clear($urandom_range(0, 9));
    end
    resp_rand_en = 1'b0;

`ifdef LLKI_KEY_SENDER_TIMEOUT_EN
    begin
      int c;
      exp_clr.push_back(TMO);
      exp_status.push_back(S_TMO);
      send_cmd(1'b1, 0);
      wait_idle();
      exp_status.push_back(S_TMO);
      send_cmd(1'b0, 2);
      c = 1;
      for (int i = 0; i < 100; i++) begin
        @(posedge clk); #1;
        if (llkid_key_valid) c++;
        else break;
      end
      check("load_timeout_valid_len", 64'(c), 64'(TMO));
      wait_idle();
    end
`endif

    repeat (3) @(posedge clk);
    check("words_left", 64'(exp_words.size()), 64'd0);
    check("status_left", 64'(exp_status.size()), 64'd0);
    check("clears_left", 64'(exp_clr.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/llki_key_sender.md
# llki_key_sender

Initiator end of the LLKI discrete key-load interface. Accepts load/clear commands from the LLKI control logic, streams 64-bit key words from an internal key buffer onto llkid_key_data with a valid/ready handshake, then waits for the core's key_complete or clear_key_ack. Sits between the LLKI command decoder and each core's mock TSS wrapper, which is the receiving end.

## Interface
- MAX_KEY_WORDS, 8, key buffer depth in 64-bit words; maximum legal load length
- TIMEOUT_CYCLES, 1024, cycles waited for any single core-side event before abort
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- buf_wr_en  in  1  key buffer write strobe
- buf_wr_addr  in  $clog2(MAX_KEY_WORDS)  key buffer word address
- buf_wr_data  in  64  key buffer write data
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  1  0 = load key, 1 = clear key
- cmd_num_words  in  $clog2(MAX_KEY_WORDS+1)  words to send on load; ignored on clear
- resp_valid  out  1  response pending
- resp_ready  in  1  response consumed when resp_valid && resp_ready
- resp_status  out  2  00 OK, 01 TIMEOUT, 10 BAD_LEN, 11 PROTOCOL
- busy  out  1  high whenever state != IDLE
- llkid_key_data  out  64  current key word
- llkid_key_valid  out  1  key word valid
- llkid_key_ready  in  1  core accepts word
- llkid_key_complete  in  1  core reports full key loaded
- llkid_clear_key  out  1  clear request
- llkid_clear_key_ack  in  1  core acknowledges clear

## Operation
- States: IDLE, SEND, WAIT_COMPLETE, CLEAR, RESP.
- IDLE: cmd_ready = 1. On accept with cmd_op = 0: if cmd_num_words == 0 or > MAX_KEY_WORDS → RESP/BAD_LEN, no LLKI activity; else load word 0 into llkid_key_data, assert llkid_key_valid → SEND. With cmd_op = 1: assert llkid_clear_key → CLEAR.
- SEND: word transfers on a cycle with valid && ready. Data/valid stay stable until then. After non-final transfer, next word is presented the following cycle with valid held high (one word per cycle max). After final transfer, valid drops → WAIT_COMPLETE. llkid_key_complete high while in SEND → drop valid, RESP/PROTOCOL.
- WAIT_COMPLETE: llkid_key_complete high → RESP/OK.
- CLEAR: llkid_clear_key held high until llkid_clear_key_ack sampled high; then deassert → RESP/OK.
- RESP: resp_valid = 1, resp_status stable; on resp_ready → IDLE. cmd_ready = 0 outside IDLE.
- Key buffer: writes honoured only while busy = 0; writes while busy ignored so the in-flight key cannot change. Buffer contents not reset.
- Word order: address 0 first, ascending to cmd_num_words-1.

## Timing
- Reset (async, rst low): state IDLE; cmd_ready 0 while in reset, 1 from first edge after release; resp_valid 0, resp_status 00, busy 0, llkid_key_data 0, llkid_key_valid 0, llkid_clear_key 0; timeout counter 0. Reset mid-transfer drops valid/clear immediately, no response.
- Command accepted at edge N → llkid_key_valid or llkid_clear_key high from N+1.
- Final transfer at edge M → valid low from M+1; complete sampled at edge C → resp_valid from C+1.
- BAD_LEN: resp_valid the cycle after accept.
- Ack/complete already high on entry is honoured on the first sampled edge in that state.

## Configuration
- LLKI_KEY_SENDER_TIMEOUT_EN defined: counter clears on state entry and each word transfer, increments every waiting cycle in SEND, WAIT_COMPLETE, CLEAR; if the event is still absent when counter == TIMEOUT_CYCLES-1, outputs drop next edge and → RESP/TIMEOUT (valid/clear held exactly TIMEOUT_CYCLES cycles).
- Not defined: no counter, waits indefinitely; TIMEOUT status never produced.

## Test plan
- Load 4 words 0x1111..., 0x2222..., 0x3333..., 0x4444..., ready tied high, complete 2 cycles after last → 4 consecutive transfers in order, resp OK.
- Same load with ready toggling every other cycle → data held stable while ready low, no duplicate/skipped words.
- cmd_num_words = 0 and = MAX_KEY_WORDS+1 → BAD_LEN next cycle, key_valid never asserted.
- Clear with ack after 5 cycles → clear_key high exactly 5 cycles, resp OK; with TIMEOUT_CYCLES=16 and no ack → clear_key high 16 cycles, resp TIMEOUT (macro defined).
- complete asserted after word 1 of 3 → valid drops, resp PROTOCOL.
- rst pulled low mid-SEND and buffer write while busy → outputs zero immediately; ignored write does not alter the transmitted word.
